// File: rtl/ui_io_controller.sv
// Memory-mapped UI controller for pushbuttons, switches, LEDs and a seven-segment display.
// Keys and switches are synchronised and debounced. Press/change events are latched in W1C registers.
module ui_io_controller #(
    parameter int DBITS    = 32,
    parameter int NUM_KEYS = 4,
    parameter int NUM_SW   = 10,
    parameter int NUM_LED  = 10,
    parameter int NUM_HEX  = 4,
    parameter int DEB_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           addr,
    input  logic                 wr_en,
    input  logic [DBITS-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [DBITS-1:0]     rd_data,
    output logic                 irq,
    input  logic [NUM_KEYS-1:0]  KEYS,
    input  logic [NUM_SW-1:0]    SWITCHES,
    output logic [NUM_LED-1:0]   LED,
    output logic [7*NUM_HEX-1:0] HEX
);

    typedef enum logic [2:0] {
        A_KEY_DATA = 3'd0,
        A_KEY_EDGE = 3'd1,
        A_SW_DATA  = 3'd2,
        A_SW_EDGE  = 3'd3,
        A_LEDR     = 3'd4,
        A_HEXVAL   = 3'd5,
        A_HEXBLANK = 3'd6,
        A_CTRL     = 3'd7
    } reg_addr_e;

    localparam int NIN = NUM_KEYS + NUM_SW;

    // Keys are inverted up front so every input bit is "1 = active" and resets to 0.
    logic [NIN-1:0]      raw_in, sync1_q, sync2_q, deb_q, deb_d, flip;
    logic [DEB_BITS-1:0] cnt_q [NIN];
    logic [DEB_BITS-1:0] cnt_d [NIN];

    logic [NUM_KEYS-1:0]  key_edge_q, key_edge_d, key_clr;
    logic [NUM_SW-1:0]    sw_edge_q, sw_edge_d, sw_clr;
    logic [NUM_LED-1:0]   led_q, led_d;
    logic [4*NUM_HEX-1:0] hexval_q, hexval_d;
    logic [NUM_HEX-1:0]   hexblank_q, hexblank_d;
    logic [1:0]           ctrl_q, ctrl_d;
    logic [DBITS-1:0]     rd_mux, rd_data_q, rd_data_d;
    logic                 irq_q, irq_d;
    logic                 unused_wr;

    assign raw_in    = {SWITCHES, ~KEYS};
    assign unused_wr = ^wr_data;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        deb_d = deb_q;
        flip  = '0;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (&cnt_q[i]) begin
                    deb_d[i] = sync2_q[i];
                    flip[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        key_clr    = '0;
        sw_clr     = '0;
        led_d      = led_q;
        hexval_d   = hexval_q;
        hexblank_d = hexblank_q;
        ctrl_d     = ctrl_q;
        if (wr_en) begin
            case (addr)
                A_KEY_EDGE: key_clr    = wr_data[NUM_KEYS-1:0];
                A_SW_EDGE:  sw_clr     = wr_data[NUM_SW-1:0];
                A_LEDR:     led_d      = wr_data[NUM_LED-1:0];
                A_HEXVAL:   hexval_d   = wr_data[4*NUM_HEX-1:0];
                A_HEXBLANK: hexblank_d = wr_data[NUM_HEX-1:0];
                A_CTRL:     ctrl_d     = wr_data[1:0];
                default:    ;
            endcase
        end
        // A new event in the same cycle as its clear wins.
        key_edge_d = (key_edge_q & ~key_clr) | (flip[NUM_KEYS-1:0] & deb_d[NUM_KEYS-1:0]);
        sw_edge_d  = (sw_edge_q & ~sw_clr) | flip[NIN-1:NUM_KEYS];
        irq_d      = (|key_edge_q & ctrl_q[0]) | (|sw_edge_q & ctrl_q[1]);
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_KEY_DATA: rd_mux[NUM_KEYS-1:0]  = deb_q[NUM_KEYS-1:0];
            A_KEY_EDGE: rd_mux[NUM_KEYS-1:0]  = key_edge_q;
            A_SW_DATA:  rd_mux[NUM_SW-1:0]    = deb_q[NIN-1:NUM_KEYS];
            A_SW_EDGE:  rd_mux[NUM_SW-1:0]    = sw_edge_q;
            A_LEDR:     rd_mux[NUM_LED-1:0]   = led_q;
            A_HEXVAL:   rd_mux[4*NUM_HEX-1:0] = hexval_q;
            A_HEXBLANK: rd_mux[NUM_HEX-1:0]   = hexblank_q;
            A_CTRL:     rd_mux[1:0]           = ctrl_q;
            default:    ;
        endcase
        rd_data_d = rd_en ? rd_mux : rd_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            // NOTE: the debounce counters are an array of flops, not a RAM; they must clear on reset.
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
            key_edge_q <= '0;
            sw_edge_q  <= '0;
            led_q      <= '0;
            hexval_q   <= '0;
            hexblank_q <= '0;
            ctrl_q     <= '0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
            key_edge_q <= key_edge_d;
            sw_edge_q  <= sw_edge_d;
            led_q      <= led_d;
            hexval_q   <= hexval_d;
            hexblank_q <= hexblank_d;
            ctrl_q     <= ctrl_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Reset forces every digit to '0' so the display is defined before the first clock edge.
    always_comb begin
        HEX = '1;
        for (int d = 0; d < NUM_HEX; d++) begin
            if (reset)              HEX[7*d +: 7] = 7'b1000000;
            else if (hexblank_q[d]) HEX[7*d +: 7] = 7'b1111111;
            else                    HEX[7*d +: 7] = seg7(hexval_q[4*d +: 4]);
        end
    end

    assign LED     = led_q;
    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_ui_io_controller.sv
// Directed bench for ui_io_controller: register map, debounce timing, W1C priority, display decode, reset.
module tb_ui_io_controller;

    localparam int DEB   = 8;
    localparam int STABLE = (1 << DEB) + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr;
    logic        wr_en, rd_en;
    logic [31:0] wr_data, rd_data;
    logic        irq;
    logic [3:0]  KEYS;
    logic [9:0]  SWITCHES;
    logic [9:0]  LED;
    logic [27:0] HEX;

    int total = 0;
    int bad   = 0;

    localparam logic [27:0] HEX_ZEROS = {4{7'b1000000}};
    localparam logic [27:0] HEX_BEEF  = {7'b1111111, 7'b0000110, 7'b0000110, 7'b0001110};

    ui_io_controller #(
        .DBITS(32), .NUM_KEYS(4), .NUM_SW(10), .NUM_LED(10), .NUM_HEX(4), .DEB_BITS(DEB)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .irq(irq), .KEYS(KEYS), .SWITCHES(SWITCHES),
        .LED(LED), .HEX(HEX)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total + 1, bad);
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
        KEYS = 4'hF; SWITCHES = '0;
        cycles(3);
        #1;
        total++;
        if (HEX !== HEX_ZEROS) begin $display("FAIL reset_hex_during: got %h want %h", HEX, HEX_ZEROS); bad++; end
        @(negedge clk); reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            total++;
            if (v !== 32'h0) begin $display("FAIL reset_reg%0d: got %h want 0", a, v); bad++; end
        end
        total++;
        if (HEX !== HEX_ZEROS) begin $display("FAIL reset_hex: got %h want %h", HEX, HEX_ZEROS); bad++; end
        total++;
        if (irq !== 1'b0 || LED !== 10'h0) begin $display("FAIL reset_irq_led: got irq=%b led=%h want 0", irq, LED); bad++; end
    endtask

    task automatic test_key_press();
        logic [31:0] v;
        @(negedge clk); KEYS = 4'b1101;
        repeat (STABLE - 1) @(posedge clk);
        rd(0, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL key_before_stable: got %h want 0", v); bad++; end
        rd(0, v);
        total++;
        if (v !== 32'h2) begin $display("FAIL key_data: got %h want 2", v); bad++; end
        rd(1, v);
        total++;
        if (v !== 32'h2) begin $display("FAIL key_edge: got %h want 2", v); bad++; end
        wr(7, 32'h1);
        total++;
        if (irq !== 1'b0) begin $display("FAIL irq_latency: got %b want 0", irq); bad++; end
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b1) begin $display("FAIL irq_key: got %b want 1", irq); bad++; end
        wr(1, 32'h2);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) begin $display("FAIL irq_after_w1c: got %b want 0", irq); bad++; end
        rd(1, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL key_edge_w1c: got %h want 0", v); bad++; end
        @(negedge clk); KEYS = 4'hF;
        cycles(STABLE + 10);
        rd(0, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL key_release_data: got %h want 0", v); bad++; end
        rd(1, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL key_release_edge: got %h want 0", v); bad++; end
    endtask

    task automatic test_switch();
        logic [31:0] v;
        @(negedge clk); SWITCHES = 10'h008;
        cycles((1 << DEB) - 1);
        SWITCHES = 10'h000;
        cycles(STABLE + 10);
        rd(2, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL sw_glitch_data: got %h want 0", v); bad++; end
        rd(3, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL sw_glitch_edge: got %h want 0", v); bad++; end
        @(negedge clk); SWITCHES = 10'h008;
        cycles(STABLE + 4);
        rd(2, v);
        total++;
        if (v !== 32'h8) begin $display("FAIL sw_data: got %h want 8", v); bad++; end
        rd(3, v);
        total++;
        if (v !== 32'h8) begin $display("FAIL sw_edge: got %h want 8", v); bad++; end
        total++;
        if (irq !== 1'b0) begin $display("FAIL sw_irq_masked: got %b want 0", irq); bad++; end
        wr(7, 32'h3);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b1) begin $display("FAIL sw_irq: got %b want 1", irq); bad++; end
        wr(3, 32'h8);
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) begin $display("FAIL sw_irq_clear: got %b want 0", irq); bad++; end
    endtask

    task automatic test_display();
        logic [31:0] v;
        wr(5, 32'h0000BEEF);
        wr(6, 32'h8);
        total++;
        if (HEX !== HEX_BEEF) begin $display("FAIL hex_beef: got %h want %h", HEX, HEX_BEEF); bad++; end
        rd(5, v);
        total++;
        if (v !== 32'h0000BEEF) begin $display("FAIL hexval_read: got %h want 0000beef", v); bad++; end
        wr(4, 32'hFFFF_FFFF);
        total++;
        if (LED !== 10'h3FF) begin $display("FAIL led_out: got %h want 3ff", LED); bad++; end
        rd(4, v);
        total++;
        if (v !== 32'h3FF) begin $display("FAIL led_read: got %h want 3ff", v); bad++; end
        // Read and write of the same address in one cycle returns the old value.
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd4; wr_data = 32'h155;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if (rd_data !== 32'h3FF) begin $display("FAIL rd_wr_same: got %h want 3ff", rd_data); bad++; end
        wr(2, 32'h3FF);
        rd(2, v);
        total++;
        if (v !== 32'h8) begin $display("FAIL ro_write_ignored: got %h want 8", v); bad++; end
    endtask

    task automatic test_set_wins();
        logic [31:0] v;
        @(negedge clk); KEYS = 4'b1110;
        cycles(STABLE + 4);
        @(negedge clk); KEYS = 4'hF;
        cycles(STABLE + 4);
        rd(1, v);
        total++;
        if (v !== 32'h1) begin $display("FAIL key0_first_edge: got %h want 1", v); bad++; end
        @(negedge clk); KEYS = 4'b1110;
        repeat (STABLE - 1) @(posedge clk);
        wr(1, 32'h1);
        rd(1, v);
        total++;
        if (v !== 32'h1) begin $display("FAIL set_wins: got %h want 1", v); bad++; end
        wr(1, 32'h1);
        rd(1, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL w1c_alone: got %h want 0", v); bad++; end
        @(negedge clk); KEYS = 4'hF;
        cycles(STABLE + 4);
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] v;
        wr(4, 32'h3FF);
        @(negedge clk); KEYS = 4'b1011;
        cycles(STABLE / 2);
        reset = 1'b1;
        #1;
        total++;
        if (HEX !== HEX_ZEROS) begin $display("FAIL hex_in_reset: got %h want %h", HEX, HEX_ZEROS); bad++; end
        @(negedge clk); reset = 1'b0;
        total++;
        if (LED !== 10'h0) begin $display("FAIL reset_led: got %h want 0", LED); bad++; end
        cycles(STABLE - 20);
        rd(0, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL mid_reset_data: got %h want 0", v); bad++; end
        rd(1, v);
        total++;
        if (v !== 32'h0) begin $display("FAIL mid_reset_edge: got %h want 0", v); bad++; end
        cycles(30);
        rd(1, v);
        total++;
        if (v !== 32'h4) begin $display("FAIL post_reset_edge: got %h want 4", v); bad++; end
        @(negedge clk); KEYS = 4'hF;
    endtask

    initial begin
        test_reset();
        test_key_press();
        test_switch();
        test_display();
        test_set_wins();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
